// File: rtl/btb_predictor_if.sv
// Fetch-lookup and ID-resolution signals between the pipeline and the branch target buffer.
// No valid/ready pair: a lookup is served every cycle, an update is qualified by upd_valid alone and is always accepted.
interface btb_predictor_if #(
  parameter int WORD_SIZE = 16
);
  logic [WORD_SIZE-1:0] pc;
  logic [WORD_SIZE-1:0] pred_pc;
  logic                 pred_taken;
  logic                 upd_valid;
  logic [WORD_SIZE-1:0] upd_pc;
  logic [WORD_SIZE-1:0] upd_target;
  logic                 upd_taken;
  logic                 upd_mispred;
  logic [WORD_SIZE-1:0] mispred_cnt;
  logic [WORD_SIZE-1:0] upd_cnt;

  modport master (
    output pc, upd_valid, upd_pc, upd_target, upd_taken, upd_mispred,
    input  pred_pc, pred_taken, mispred_cnt, upd_cnt
  );

  modport slave (
    input  pc, upd_valid, upd_pc, upd_target, upd_taken, upd_mispred,
    output pred_pc, pred_taken, mispred_cnt, upd_cnt
  );
endinterface

// File: rtl/btb_predictor.sv
// Direct-mapped branch target buffer with 2-bit counters: combinational lookup,
// single-cycle update, saturating resolution/misprediction counters.
module btb_predictor #(
  parameter int WORD_SIZE = 16,
  parameter int IDX_BITS  = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  btb_predictor_if.slave   bus
);
  localparam int ENTRIES = 1 << IDX_BITS;
  localparam int TAG_W   = WORD_SIZE - IDX_BITS;

  logic [ENTRIES-1:0]   valid_q;
  logic [TAG_W-1:0]     tag_q    [ENTRIES];
  logic [WORD_SIZE-1:0] target_q [ENTRIES];
  logic [1:0]           ctr_q    [ENTRIES];
  logic [WORD_SIZE-1:0] mispred_cnt_q, mispred_cnt_d;
  logic [WORD_SIZE-1:0] upd_cnt_q, upd_cnt_d;

  logic [IDX_BITS-1:0]  lk_idx;
  logic                 lk_hit;
  logic                 lk_taken;

  logic [IDX_BITS-1:0]  up_idx;
  logic [TAG_W-1:0]     up_tag;
  logic                 up_hit;
  logic                 up_we;
  logic [1:0]           up_ctr_d;
  logic [WORD_SIZE-1:0] up_target_d;

  // Lookup sees pre-update contents; reset forces fall-through even with stale entries.
  assign lk_idx   = bus.pc[IDX_BITS-1:0];
  assign lk_hit   = valid_q[lk_idx] && (tag_q[lk_idx] == bus.pc[WORD_SIZE-1:IDX_BITS]);
  assign lk_taken = reset_n && lk_hit && ctr_q[lk_idx][1];

  assign bus.pred_taken  = lk_taken;
  assign bus.pred_pc     = lk_taken ? target_q[lk_idx] : bus.pc + WORD_SIZE'(1);
  assign bus.mispred_cnt = mispred_cnt_q;
  assign bus.upd_cnt     = upd_cnt_q;

  assign up_idx = bus.upd_pc[IDX_BITS-1:0];
  assign up_tag = bus.upd_pc[WORD_SIZE-1:IDX_BITS];
  assign up_hit = valid_q[up_idx] && (tag_q[up_idx] == up_tag);

  always_comb begin
    up_we       = 1'b0;
    up_ctr_d    = ctr_q[up_idx];
    up_target_d = target_q[up_idx];
    if (bus.upd_valid) begin
      if (up_hit) begin
        up_we = 1'b1;
        if (bus.upd_taken) begin
          up_ctr_d    = (ctr_q[up_idx] == 2'b11) ? 2'b11 : ctr_q[up_idx] + 2'b01;
          up_target_d = bus.upd_target;
        end else begin
          up_ctr_d    = (ctr_q[up_idx] == 2'b00) ? 2'b00 : ctr_q[up_idx] - 2'b01;
        end
      end else if (bus.upd_taken) begin
        // Miss on a taken branch evicts whatever lives at this index.
        up_we       = 1'b1;
        up_ctr_d    = 2'b10;
        up_target_d = bus.upd_target;
      end
    end
  end

  always_comb begin
    upd_cnt_d     = upd_cnt_q;
    mispred_cnt_d = mispred_cnt_q;
    if (bus.upd_valid && (upd_cnt_q != '1)) begin
      upd_cnt_d = upd_cnt_q + WORD_SIZE'(1);
    end
    if (bus.upd_valid && bus.upd_mispred && (mispred_cnt_q != '1)) begin
      mispred_cnt_d = mispred_cnt_q + WORD_SIZE'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      valid_q       <= '0;
      mispred_cnt_q <= '0;
      upd_cnt_q     <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        ctr_q[i] <= 2'b01;
      end
    end else begin
      mispred_cnt_q <= mispred_cnt_d;
      upd_cnt_q     <= upd_cnt_d;
      if (up_we) begin
        valid_q[up_idx]  <= 1'b1;
        tag_q[up_idx]    <= up_tag;
        target_q[up_idx] <= up_target_d;
        ctr_q[up_idx]    <= up_ctr_d;
      end
    end
  end
endmodule

// File: tb/tb_btb_predictor.sv
// Randomized and directed checks of btb_predictor against a table-level reference model.
module tb_btb_predictor;
  localparam int W = 16;

  logic clk;
  logic reset_n;

  btb_predictor_if #(.WORD_SIZE(W)) bus ();

  btb_predictor #(.WORD_SIZE(W), .IDX_BITS(4)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  int m_valid  [16];
  int m_tag    [16];
  int m_target [16];
  int m_ctr    [16];
  int m_upd_cnt;
  int m_mis_cnt;
  bit model_known;

  // {pred_taken, pred_pc, mispred_cnt, upd_cnt}
  logic [3*W:0] exp_q[$];
  int checks;
  int passed;

  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin
      m_valid[i] = 0;
      m_ctr[i]   = 1;
    end
    m_upd_cnt = 0;
    m_mis_cnt = 0;
  endtask

  task automatic model_update(input int upc, input int tgt, input bit tk, input bit mis);
    int idx;
    int tg;
    idx = upc % 16;
    tg  = upc / 16;
    m_upd_cnt = (m_upd_cnt >= 65535) ? 65535 : m_upd_cnt + 1;
    if (mis) m_mis_cnt = (m_mis_cnt >= 65535) ? 65535 : m_mis_cnt + 1;
    if (m_valid[idx] != 0 && m_tag[idx] == tg) begin
      if (tk) begin
        m_ctr[idx]    = (m_ctr[idx] + 1 > 3) ? 3 : m_ctr[idx] + 1;
        m_target[idx] = tgt;
      end else begin
        m_ctr[idx]    = (m_ctr[idx] - 1 < 0) ? 0 : m_ctr[idx] - 1;
      end
    end else if (tk) begin
      m_valid[idx]  = 1;
      m_tag[idx]    = tg;
      m_target[idx] = tgt;
      m_ctr[idx]    = 2;
    end
  endtask

  // ---------------- driver ----------------
  task automatic cycle(input bit rst_n, input int pc, input bit uv, input int upc,
                       input int tgt, input bit tk, input bit mis);
    int idx;
    bit tkn;
    int ppc;
    @(posedge clk);
    #1;
    reset_n         = rst_n;
    bus.pc          = W'(pc);
    bus.upd_valid   = uv;
    bus.upd_pc      = W'(upc);
    bus.upd_target  = W'(tgt);
    bus.upd_taken   = tk;
    bus.upd_mispred = mis;
    if (model_known) begin
      idx = pc % 16;
      tkn = rst_n && m_valid[idx] != 0 && m_tag[idx] == pc / 16 && m_ctr[idx] >= 2;
      ppc = tkn ? m_target[idx] : (pc + 1) % 65536;
      exp_q.push_back({tkn, W'(ppc), W'(m_mis_cnt), W'(m_upd_cnt)});
    end
    if (!rst_n) begin
      model_reset();
      model_known = 1'b1;
    end else if (uv) begin
      model_update(upc, tgt, tk, mis);
    end
  endtask

  task automatic look(input int pc);
    cycle(1'b1, pc, 1'b0, 0, 0, 1'b0, 1'b0);
  endtask

  task automatic upd(input int pc, input int upc, input int tgt, input bit tk, input bit mis);
    cycle(1'b1, pc, 1'b1, upc, tgt, tk, mis);
  endtask

  // ---------------- monitor / scoreboard ----------------
  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s pc=%h got=%h expected=%h at %0t", name, bus.pc, act, exp, $time);
  endtask

  always @(negedge clk) begin
    logic [3*W:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("pred_taken",  W'(bus.pred_taken), W'(e[3*W]));
      check("pred_pc",     bus.pred_pc,        e[3*W-1:2*W]);
      check("mispred_cnt", bus.mispred_cnt,    e[2*W-1:W]);
      check("upd_cnt",     bus.upd_cnt,        e[W-1:0]);
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int hi_pool [4];
    int pc;
    int upc;
    checks      = 0;
    passed      = 0;
    model_known = 1'b0;
    hi_pool[0]  = 16'h0010;
    hi_pool[1]  = 16'h0110;
    hi_pool[2]  = 16'h0000;
    hi_pool[3]  = 16'hFFF0;
    reset_n         = 1'b0;
    bus.pc          = '0;
    bus.upd_valid   = 1'b0;
    bus.upd_pc      = '0;
    bus.upd_target  = '0;
    bus.upd_taken   = 1'b0;
    bus.upd_mispred = 1'b0;

    cycle(1'b0, 16'h0010, 1'b0, 0, 0, 1'b0, 1'b0);
    cycle(1'b0, 16'h0010, 1'b0, 0, 0, 1'b0, 1'b0);
    look(16'h0010);
    look(16'hFFFF);

    // Allocate, then saturate down with not-taken resolutions.
    upd(16'h0010, 16'h0012, 16'h0040, 1'b1, 1'b1);
    look(16'h0012);
    upd(16'h0012, 16'h0012, 16'h0099, 1'b0, 1'b0);
    upd(16'h0012, 16'h0012, 16'h0099, 1'b0, 1'b1);
    look(16'h0012);
    upd(16'h0012, 16'h0012, 16'h0099, 1'b0, 1'b0);
    look(16'h0012);
    upd(16'h0012, 16'h0012, 16'h0050, 1'b1, 1'b0);
    look(16'h0012);
    upd(16'h0012, 16'h0012, 16'h0060, 1'b1, 1'b0);
    look(16'h0012);

    // Alias at index 2 evicts the 0x0012 entry.
    upd(16'h0012, 16'h0112, 16'h0200, 1'b1, 1'b1);
    look(16'h0012);
    look(16'h0112);

    // Same-cycle lookup and allocate at the same index.
    upd(16'h0005, 16'h0005, 16'h0077, 1'b1, 1'b0);
    look(16'h0005);

    // Mispredict flag without upd_valid; not-taken miss must not allocate.
    cycle(1'b1, 16'h0005, 1'b0, 16'h0033, 16'h0044, 1'b1, 1'b1);
    upd(16'h0033, 16'h0033, 16'h0044, 1'b0, 1'b1);
    look(16'h0033);

    // Reset wins over a simultaneous update.
    cycle(1'b0, 16'h0112, 1'b1, 16'h0030, 16'h0300, 1'b1, 1'b1);
    look(16'h0112);
    look(16'h0005);
    look(16'h0030);
    look(16'hFFFF);

    for (int n = 0; n < 3000; n++) begin
      pc  = hi_pool[$urandom_range(0, 3)] | $urandom_range(0, 15);
      upc = hi_pool[$urandom_range(0, 3)] | $urandom_range(0, 15);
      if ($urandom_range(0, 199) == 0) begin
        cycle(1'b0, pc, 1'($urandom_range(0, 1)), upc, $urandom_range(0, 65535), 1'b1, 1'b1);
      end else begin
        cycle(1'b1, pc, 1'($urandom_range(0, 2) != 0), upc, $urandom_range(0, 65535),
              1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 1)));
      end
    end
    look(16'hFFFF);

    @(posedge clk);
    @(posedge clk);
    checks++;
    if (exp_q.size() == 0) passed++;
    else $display("FAIL drain pending=%0d expected=0", exp_q.size());
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
